// File: rtl/dma_pkg.sv
// Shared types for the strided MM2S DMA: FSM state encoding, beat counter width
// and the AXI read-master request/response bundles.
package dma_pkg;

  localparam int DMA_ADDR_W = 32;
  localparam int DMA_DATA_W = 64;
  localparam int DMA_ID_W   = 4;

  // Wide enough for the largest AXI4 INCR burst (256 beats).
  localparam int BEAT_CNT_W = 8;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_EMIT,
    ST_DONE
  } dma_state_e;

  typedef struct packed {
    logic                    ar_valid;
    logic [DMA_ADDR_W-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic [DMA_ID_W-1:0]     ar_id;
    logic                    r_ready;
    logic                    aw_valid;
    logic [DMA_ADDR_W-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic [DMA_ID_W-1:0]     aw_id;
    logic                    w_valid;
    logic [DMA_DATA_W-1:0]   w_data;
    logic [DMA_DATA_W/8-1:0] w_strb;
    logic                    w_last;
    logic                    b_ready;
  } axi_req_t;

  typedef struct packed {
    logic                  ar_ready;
    logic                  r_valid;
    logic [DMA_DATA_W-1:0] r_data;
    logic [1:0]            r_resp;
    logic                  r_last;
  } axi_resp_t;

  function automatic logic [2:0] axi_size(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/dma_pkt_assembler.sv
// Collects BEATS read beats into one packet word (beat 0 in the low bits) and
// flags any beat whose response is not OKAY or whose rlast is misplaced.
module dma_pkt_assembler
  import dma_pkg::*;
#(
  parameter int AXI_DATA_W = 64,
  parameter int BEATS      = 3
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr,
  input  logic                        beat_en,
  input  logic [AXI_DATA_W-1:0]       beat_data,
  input  logic [1:0]                  beat_resp,
  input  logic                        beat_last,
  output logic [BEATS*AXI_DATA_W-1:0] pkt_data,
  output logic                        pkt_full,
  output logic                        beat_err
);

  logic [BEAT_CNT_W-1:0]            beat_cnt_q;
  logic [BEATS-1:0][AXI_DATA_W-1:0] buf_q;
  logic                             is_last;

  assign is_last  = (beat_cnt_q == BEAT_CNT_W'(BEATS - 1));
  assign pkt_full = beat_en && is_last;
  assign beat_err = beat_en && ((beat_resp != AXI_RESP_OKAY) || (beat_last != is_last));
  assign pkt_data = buf_q;

  // The buffer is only written in R, so it holds steady while the packet is offered.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      beat_cnt_q <= '0;
      buf_q      <= '0;
    end else begin
      if (clr)
        beat_cnt_q <= '0;
      else if (beat_en)
        beat_cnt_q <= is_last ? '0 : beat_cnt_q + 1'b1;
      for (int k = 0; k < BEATS; k++)
        if (beat_en && beat_cnt_q == BEAT_CNT_W'(k))
          buf_q[k] <= beat_data;
    end
  end

endmodule

// File: rtl/axis_dma_mm2s_strided.sv
// Strided memory-to-stream DMA: one AXI INCR burst per packet, each packet sent
// as a single AXIS word. Define AXIS_DMA_STRIDE_EN to step by the stride port.
module axis_dma_mm2s_strided
  import dma_pkg::*;
#(
  parameter int AXI_ADDR_W = DMA_ADDR_W,
  parameter int AXI_DATA_W = DMA_DATA_W,
  parameter int AXI_ID_W   = DMA_ID_W,
  parameter int AXIS_W     = 192
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [AXI_ADDR_W-1:0] src_addr,
  input  logic [AXI_ADDR_W-1:0] stride,
  input  logic [31:0]           len_pkts,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           pkts_done,
  output axi_req_t              axi_o,
  input  axi_resp_t             axi_i,
  output logic [AXIS_W-1:0]     m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast
);

  localparam int BEATS     = AXIS_W / AXI_DATA_W;
  localparam int PKT_BYTES = BEATS * AXI_DATA_W / 8;

  dma_state_e            state_q, state_d;
  logic [AXI_ADDR_W-1:0] addr_q, addr_inc;
  logic [31:0]           left_q, pkts_done_q;
  logic                  done_q, err_q, abort_q;
  logic                  ar_valid, r_ready, beat_en, pkt_full, beat_err;
  logic                  last_pkt, emit_hs, launch;

`ifdef AXIS_DMA_STRIDE_EN
  logic [AXI_ADDR_W-1:0] stride_q;

  always_ff @(posedge clk) begin
    if (!rstn)
      stride_q <= '0;
    else if (launch)
      stride_q <= stride;
  end

  assign addr_inc = stride_q;
`else
  assign addr_inc = AXI_ADDR_W'(PKT_BYTES);
`endif

  assign launch   = (state_q == ST_IDLE) && start && (len_pkts != 32'd0);
  assign last_pkt = (left_q == 32'd1);
  assign emit_hs  = (state_q == ST_EMIT) && m_axis_tready;
  assign beat_en  = r_ready && axi_i.r_valid;

  always_ff @(posedge clk) begin
    if (!rstn)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    busy          = 1'b0;
    ar_valid      = 1'b0;
    r_ready       = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start)
          state_d = (len_pkts != 32'd0) ? ST_AR : ST_DONE;
      end
      ST_AR: begin
        busy     = 1'b1;
        ar_valid = 1'b1;
        if (axi_i.ar_ready)
          state_d = ST_R;
      end
      ST_R: begin
        busy    = 1'b1;
        r_ready = 1'b1;
        if (pkt_full)
          state_d = ST_EMIT;
      end
      ST_EMIT: begin
        busy          = 1'b1;
        m_axis_tvalid = 1'b1;
        m_axis_tlast  = last_pkt;
        // An abort arriving on the handshake cycle itself also ends the transfer here.
        if (m_axis_tready)
          state_d = (last_pkt || abort_q || abort || err_q) ? ST_DONE : ST_AR;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      addr_q      <= '0;
      left_q      <= '0;
      pkts_done_q <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      abort_q     <= 1'b0;
    end else begin
      if (launch) begin
        addr_q      <= src_addr;
        left_q      <= len_pkts;
        pkts_done_q <= '0;
        done_q      <= 1'b0;
        err_q       <= 1'b0;
        abort_q     <= 1'b0;
      end
      if (busy && abort)
        abort_q <= 1'b1;
      if (beat_err)
        err_q <= 1'b1;
      if (emit_hs) begin
        pkts_done_q <= pkts_done_q + 32'd1;
        left_q      <= left_q - 32'd1;
        addr_q      <= addr_q + addr_inc;
      end
      if (state_q == ST_DONE)
        done_q <= 1'b1;
    end
  end

  dma_pkt_assembler #(
    .AXI_DATA_W (AXI_DATA_W),
    .BEATS      (BEATS)
  ) u_asm (
    .clk       (clk),
    .rstn      (rstn),
    .clr       (launch),
    .beat_en   (beat_en),
    .beat_data (axi_i.r_data),
    .beat_resp (axi_i.r_resp),
    .beat_last (axi_i.r_last),
    .pkt_data  (m_axis_tdata),
    .pkt_full  (pkt_full),
    .beat_err  (beat_err)
  );

  // Read-only master: the write channels are tied off.
  always_comb begin
    axi_o          = '0;
    axi_o.ar_valid = ar_valid;
    axi_o.ar_addr  = addr_q;
    axi_o.ar_len   = 8'(BEATS - 1);
    axi_o.ar_size  = axi_size(AXI_DATA_W);
    axi_o.ar_burst = AXI_BURST_INCR;
    axi_o.ar_id    = DMA_ID_W'({AXI_ID_W{1'b0}});
    axi_o.r_ready  = r_ready;
  end

  assign done      = done_q;
  assign err       = err_q;
  assign pkts_done = pkts_done_q;

endmodule
